// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle CPU.
// Sequences IF/ID/EXE/MEM/WB and drives datapath controls.
module multicycle_control_unit #(
  parameter int             OP_W    = 6,
  parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic [2:0]      state,
  output logic            PCWre,
  output logic            InsMemRW,
  output logic            IRWre,
  output logic [1:0]      Extsel,
  output logic [1:0]      RegOut,
  output logic            RegWre,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            ALUM2Reg,
  output logic            WrRegData,
  output logic [1:0]      PCSrc,
  output logic            DataMemRW
);

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE_M = 3'b010,
    S_MEM   = 3'b011,
    S_WB_L  = 3'b100,
    S_EXE_B = 3'b101,
    S_EXE_A = 3'b110,
    S_WB_A  = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR    = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND   = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;

  state_t cur, nxt;

  logic is_add, is_sub, is_addi, is_or, is_and;
  logic is_ori, is_sll, is_slt, is_sltiu;
  logic is_sw, is_lw, is_beq, is_j, is_jr, is_jal;
  logic is_r, is_i, is_alu, is_mem, is_halt;

  assign is_add   = opcode == OP_ADD;
  assign is_sub   = opcode == OP_SUB;
  assign is_addi  = opcode == OP_ADDI;
  assign is_or    = opcode == OP_OR;
  assign is_and   = opcode == OP_AND;
  assign is_ori   = opcode == OP_ORI;
  assign is_sll   = opcode == OP_SLL;
  assign is_slt   = opcode == OP_SLT;
  assign is_sltiu = opcode == OP_SLTIU;
  assign is_sw    = opcode == OP_SW;
  assign is_lw    = opcode == OP_LW;
  assign is_beq   = opcode == OP_BEQ;
  assign is_j     = opcode == OP_J;
  assign is_jr    = opcode == OP_JR;
  assign is_jal   = opcode == OP_JAL;
  assign is_halt  = opcode == HALT_OP;

  assign is_r   = is_add | is_sub | is_or | is_and
                | is_sll | is_slt;
  assign is_i   = is_addi | is_ori | is_sltiu;
  assign is_alu = is_r | is_i;
  assign is_mem = is_sw | is_lw;

  assign state = cur;

  // ALU settings for arithmetic ops, held EXE_A through WB_A
  logic [2:0] a_op;
  logic       a_src_a;
  logic       a_src_b;
  logic [1:0] a_ext;

  always_comb begin
    a_op    = 3'b000;
    a_src_a = 1'b0;
    a_src_b = 1'b0;
    a_ext   = 2'b00;
    unique case (1'b1)
      is_sub:   a_op = 3'b001;
      is_or:    a_op = 3'b011;
      is_and:   a_op = 3'b100;
      is_slt:   a_op = 3'b110;
      is_addi: begin
        a_src_b = 1'b1;
        a_ext   = 2'b01;
      end
      is_ori: begin
        a_op    = 3'b011;
        a_src_b = 1'b1;
      end
      is_sltiu: begin
        a_op    = 3'b101;
        a_src_b = 1'b1;
        a_ext   = 2'b01;
      end
      is_sll: begin
        a_op    = 3'b010;
        a_src_a = 1'b1;
        a_ext   = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cur <= S_IF;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IF: nxt = S_ID;
      S_ID: begin
        unique case (1'b1)
          is_beq:  nxt = S_EXE_B;
          is_mem:  nxt = S_EXE_M;
          is_alu:  nxt = S_EXE_A;
          is_halt: nxt = S_ID;
          default: nxt = S_IF;
        endcase
      end
      S_EXE_A: nxt = S_WB_A;
      S_WB_A:  nxt = S_IF;
      S_EXE_B: nxt = S_IF;
      S_EXE_M: nxt = S_MEM;
      S_MEM:   nxt = is_sw ? S_IF : S_WB_L;
      S_WB_L:  nxt = S_IF;
      default: nxt = S_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    InsMemRW  = 1'b0;
    IRWre     = 1'b0;
    Extsel    = 2'b00;
    RegOut    = 2'b00;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    ALUM2Reg  = 1'b0;
    WrRegData = 1'b0;
    PCSrc     = 2'b00;
    DataMemRW = 1'b0;
    unique case (cur)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      S_ID: begin
        unique case (1'b1)
          is_j: begin
            PCSrc = 2'b11;
            PCWre = 1'b1;
          end
          is_jr: begin
            PCSrc = 2'b10;
            PCWre = 1'b1;
          end
          is_jal: begin
            PCSrc  = 2'b11;
            RegWre = 1'b1;
            PCWre  = 1'b1;
          end
          is_beq, is_mem, is_alu, is_halt: ;
          default: PCWre = 1'b1;
        endcase
      end
      S_EXE_A, S_WB_A: begin
        ALUOp   = a_op;
        ALUSrcA = a_src_a;
        ALUSrcB = a_src_b;
        Extsel  = a_ext;
        if (cur == S_WB_A) begin
          RegWre    = 1'b1;
          WrRegData = 1'b1;
          RegOut    = is_r ? 2'b10 : 2'b01;
          PCWre     = 1'b1;
        end
      end
      S_EXE_B: begin
        ALUOp  = 3'b001;
        Extsel = 2'b01;
        PCWre  = 1'b1;
        PCSrc  = zero ? 2'b01 : 2'b00;
      end
      S_EXE_M, S_MEM, S_WB_L: begin
        ALUSrcB = 1'b1;
        Extsel  = 2'b01;
        if (cur == S_MEM && is_sw) begin
          DataMemRW = 1'b1;
          PCWre     = 1'b1;
        end
        if (cur == S_WB_L) begin
          RegWre    = 1'b1;
          RegOut    = 2'b01;
          WrRegData = 1'b1;
          ALUM2Reg  = 1'b1;
          PCWre     = 1'b1;
        end
      end
      default: ;
    endcase
    // reset aborts any in-flight write
    if (reset) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      DataMemRW = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit.
// Instruction-level model: per-opcode path and per-step controls.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic [2:0] state;
  logic       PCWre, InsMemRW, IRWre, RegWre;
  logic       ALUSrcA, ALUSrcB, ALUM2Reg, WrRegData, DataMemRW;
  logic [1:0] Extsel, RegOut, PCSrc;
  logic [2:0] ALUOp;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .state(state), .PCWre(PCWre), .InsMemRW(InsMemRW),
    .IRWre(IRWre), .Extsel(Extsel), .RegOut(RegOut),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ALUM2Reg(ALUM2Reg), .WrRegData(WrRegData),
    .PCSrc(PCSrc), .DataMemRW(DataMemRW)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [17:0] ctrl;
  assign ctrl = {PCWre, InsMemRW, IRWre, Extsel, RegOut, RegWre,
                 ALUSrcA, ALUSrcB, ALUOp, ALUM2Reg, WrRegData,
                 PCSrc, DataMemRW};

  logic [3:0] enables;
  assign enables = {PCWre, IRWre, RegWre, DataMemRW};

  typedef enum {K_J, K_JR, K_JAL, K_BEQ, K_SW, K_LW,
                K_AR, K_AI, K_UNK} kind_t;

  logic [5:0] known [15] = '{
    6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
    6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
    6'b110001, 6'b110100, 6'b111000, 6'b111001, 6'b111010};

  function automatic kind_t kind_of(input logic [5:0] op);
    case (op)
      6'b111000: return K_J;
      6'b111001: return K_JR;
      6'b111010: return K_JAL;
      6'b110100: return K_BEQ;
      6'b110000: return K_SW;
      6'b110001: return K_LW;
      6'b000010, 6'b010010, 6'b100111: return K_AI;
      6'b000000, 6'b000001, 6'b010000, 6'b010001,
      6'b011000, 6'b100110: return K_AR;
      default: return K_UNK;
    endcase
  endfunction

  function automatic int len_of(input kind_t k);
    case (k)
      K_BEQ:      return 3;
      K_LW:       return 5;
      K_SW:       return 4;
      K_AR, K_AI: return 4;
      default:    return 2;
    endcase
  endfunction

  // spec state codes along each instruction's path
  function automatic logic [2:0] exp_state(input kind_t k,
                                           input int s);
    if (s == 0) return 3'b000;
    if (s == 1) return 3'b001;
    case (k)
      K_BEQ:      return 3'b101;
      K_SW, K_LW: return (s == 2) ? 3'b010 :
                         (s == 3) ? 3'b011 : 3'b100;
      default:    return (s == 2) ? 3'b110 : 3'b111;
    endcase
  endfunction

  // {ALUOp, ALUSrcA, ALUSrcB, Extsel} for arithmetic opcodes
  function automatic logic [6:0] alu_cfg(input logic [5:0] op);
    case (op)
      6'b000001: return {3'd1, 1'b0, 1'b0, 2'd0};
      6'b000010: return {3'd0, 1'b0, 1'b1, 2'd1};
      6'b010000: return {3'd3, 1'b0, 1'b0, 2'd0};
      6'b010001: return {3'd4, 1'b0, 1'b0, 2'd0};
      6'b010010: return {3'd3, 1'b0, 1'b1, 2'd0};
      6'b011000: return {3'd2, 1'b1, 1'b0, 2'd2};
      6'b100110: return {3'd6, 1'b0, 1'b0, 2'd0};
      6'b100111: return {3'd5, 1'b0, 1'b1, 2'd1};
      default:   return {3'd0, 1'b0, 1'b0, 2'd0};
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(input logic [5:0] op,
                                           input int s,
                                           input logic z);
    kind_t      k;
    int         n;
    logic       pcw, imr, irw, rw, sa, sb, m2r, wrd, dmw;
    logic [1:0] ext, ro, psrc;
    logic [2:0] aop;
    k = kind_of(op);
    n = len_of(k);
    {pcw, imr, irw, rw, sa, sb, m2r, wrd, dmw} = '0;
    {ext, ro, psrc, aop} = '0;
    pcw = (s == n - 1);
    if (s == 0) begin
      imr = 1'b1;
      irw = 1'b1;
    end else if (s == 1) begin
      if (k == K_J || k == K_JAL) psrc = 2'b11;
      if (k == K_JR) psrc = 2'b10;
      if (k == K_JAL) rw = 1'b1;
    end else begin
      case (k)
        K_AR, K_AI: begin
          {aop, sa, sb, ext} = alu_cfg(op);
          if (s == 3) begin
            rw  = 1'b1;
            wrd = 1'b1;
            ro  = (k == K_AR) ? 2'b10 : 2'b01;
          end
        end
        K_BEQ: begin
          aop  = 3'd1;
          ext  = 2'd1;
          psrc = z ? 2'b01 : 2'b00;
        end
        K_SW, K_LW: begin
          sb  = 1'b1;
          ext = 2'd1;
          dmw = (k == K_SW) && (s == 3);
          if (s == 4) begin
            rw  = 1'b1;
            ro  = 2'b01;
            wrd = 1'b1;
            m2r = 1'b1;
          end
        end
        default: ;
      endcase
    end
    return {pcw, imr, irw, ext, ro, rw, sa, sb, aop, m2r, wrd,
            psrc, dmw};
  endfunction

  // called at posedge+1 with the DUT in IF; zmode<0 randomizes zero
  task automatic run_instr(input logic [5:0] op, input int zmode);
    int n;
    n = len_of(kind_of(op));
    for (int s = 0; s < n; s++) begin
      opcode = op;
      zero   = (zmode < 0) ? 1'($urandom_range(1)) : 1'(zmode);
      #2;
      check($sformatf("state op=%b s=%0d", op, s),
            32'(state), 32'(exp_state(kind_of(op), s)));
      check($sformatf("ctrl op=%b s=%0d", op, s),
            32'(ctrl), 32'(exp_ctrl(op, s, zero)));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    bit         hit;
    if ($urandom_range(9) != 0)
      return known[$urandom_range(14)];
    do begin
      op  = 6'($urandom);
      hit = (op == 6'b111111);
      foreach (known[i]) if (known[i] == op) hit = 1'b1;
    end while (hit);
    return op;
  endfunction

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    check("reset en e1", 32'(enables), 32'h0);
    @(posedge clk);
    #1;
    check("reset state", 32'(state), 32'h0);
    check("reset en e2", 32'(enables), 32'h0);
    reset = 1'b0;
    #1;
    check("post-reset IRWre", 32'(IRWre), 32'h1);
    check("post-reset state", 32'(state), 32'h0);

    run_instr(6'b000000, 0);
    run_instr(6'b110001, 0);
    run_instr(6'b110100, 1);
    run_instr(6'b110100, 0);
    run_instr(6'b111010, 0);

    for (int i = 0; i < 300; i++)
      run_instr(pick_op(), -1);

    // halt: stuck in ID with everything low until reset
    opcode = 6'b111111;
    #2;
    check("halt IF", 32'(state), 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 50; i++) begin
      zero = 1'($urandom_range(1));
      #2;
      check("halt state", 32'(state), 32'h1);
      check("halt ctrl", 32'(ctrl), 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #2;
    check("halt reset en", 32'(enables), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("halt exit state", 32'(state), 32'h0);
    @(posedge clk);
    #1;
    check("halt exit ID", 32'(state), 32'h1);
    opcode = 6'b000000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("resume IF", 32'(state), 32'h0);

    // sw aborted by reset in MEM
    opcode = 6'b110000;
    for (int s = 0; s < 3; s++) begin
      #2;
      check($sformatf("sw pre s=%0d", s), 32'(state),
            32'(exp_state(K_SW, s)));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #2;
    check("sw abort state", 32'(state), 32'h3);
    check("sw abort DataMemRW", 32'(DataMemRW), 32'h0);
    check("sw abort PCWre", 32'(PCWre), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("sw abort next", 32'(state), 32'h0);
    run_instr(6'b100111, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
